iot_event_arbiter: RTL
======================

IOT_EVENT_ARBITER -- requirements
Module: iot_event_arbiter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 8'd255, which is the highest legal device count when the guard is compiled in.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: per-gateway event request, level, held until granted or rejected.
REQ-005 SHALL have port req_on, input, 4 bits: per-gateway direction; 1 = device joined (up), 0 = device left (down); valid while req[i]=1.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot one-cycle grant pulse, registered.
REQ-007 SHALL have port rej, output, 4 bits: one-hot one-cycle reject pulse, registered.
REQ-008 SHALL have port mon_change, output, 1 bit: change strobe to the device counter, registered.
REQ-009 SHALL have port mon_on_off, output, 1 bit: direction to the device counter; valid when mon_change=1.
REQ-010 SHALL have port shadow_count, output, 8 bits: mirror of the device counter value after all issued strobes.

Function
REQ-011 SHALL run a 2-state FSM: IDLE (no response issued this cycle) and ISSUE (exactly one of gnt/rej high this cycle).
REQ-012 SHALL, at each rising edge, select one winner among eligible requesters: req[i]=1 AND gnt[i]=0 AND rej[i]=0 in the current cycle.
REQ-013 SHALL go to ISSUE if any requester is eligible, else IDLE; ISSUE->ISSUE back-to-back is allowed, giving one event per cycle maximum.
REQ-014 SHALL use round-robin priority starting at (ptr+1) mod 4, where ptr is the index of the last winner; ptr resets to 3 so that gateway 0 has first priority.
REQ-015 SHALL update ptr on every winner, whether granted or rejected.
REQ-016 SHALL respond with 1-cycle latency: req sampled at edge N produces gnt/rej high for the cycle after edge N.
REQ-017 SHALL, on a grant, assert gnt[w]=1, mon_change=1 and mon_on_off=req_on[w] in the same cycle.
REQ-018 SHALL, in the same edge as a grant, set shadow_count to shadow_count+1 if req_on[w]=1, else to shadow_count-1.
REQ-019 SHALL hold mon_change=0, mon_on_off=0 and shadow_count unchanged in IDLE and on a reject.
REQ-020 SHALL never assert more than one bit across gnt|rej in any cycle.
REQ-021 SHALL exclude a requester in its response cycle; if it keeps req high, it becomes eligible again one cycle later, so no double-count is possible.
REQ-022 SHALL ignore req_on[i] while req[i]=0.
REQ-023 SHALL continue arbitrating among the other requesters when one requester drops req before being served; the dropped request is lost with no response.

Reset
REQ-024 SHALL, while rst=1, immediately force gnt=0, rej=0, mon_change=0, mon_on_off=0, shadow_count=0, ptr=3 and state=IDLE, regardless of clk.
REQ-025 SHALL cancel any in-flight response when rst asserts mid-operation; the pending request is re-arbitrated after release if req is still high.
REQ-026 SHALL issue the first response no earlier than the cycle after the first rising edge following rst deassertion.

Configuration
REQ-027 SHALL, with macro IOT_SATURATE_GUARD_EN defined, reject (rej[w]=1, no strobe) an up-request when shadow_count==MAX_COUNT and a down-request when shadow_count==0.
REQ-028 SHALL, without IOT_SATURATE_GUARD_EN, grant every winner, hold rej constant 0, ignore MAX_COUNT, and let shadow_count wrap mod 256 (255+1=0, 0-1=255).

Verification
REQ-029 SHALL cover: after reset, req=4'b0001, req_on=1 held 3 cycles -> gnt[0] pulses in cycles 2 and 4 only, shadow_count reaches 2, mon_change matches gnt.
REQ-030 SHALL cover: req=4'b1111 held, all req_on=1 -> grant order 0,1,2,3,0 on consecutive cycles; shadow_count +1 per cycle.
REQ-031 SHALL cover: with guard, shadow_count=0 and a down-request on gateway 2 -> rej=4'b0100, mon_change=0, count stays 0; without guard -> gnt[2]=1, count=255.
REQ-032 SHALL cover: with guard and MAX_COUNT=3, count driven to 3, then up-request -> rej pulse, count stays 3; a down-request next -> count=2.
REQ-033 SHALL cover: rst pulsed asynchronously between edges while gnt[1]=1 -> all outputs 0 immediately, shadow_count=0, next grant goes to lowest-index requester.
REQ-034 SHALL cover: gateway 3 asserts req for 1 cycle while gateway 0 is granted and then drops req -> no gnt[3]/rej[3] issued, count unaffected by it.

Source files
------------

// File: rtl/iot_event_arbiter.sv
// rtl/iot_event_arbiter.sv - round-robin arbiter for IoT gateway join/leave events with shadow device count
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   req[3:0]     : per-gateway event request (level)
//   req_on[3:0]  : per-gateway direction, 1 = device joined, 0 = device left
//   gnt[3:0]     : one-hot one-cycle grant pulse (registered)
//   rej[3:0]     : one-hot one-cycle reject pulse (registered)
//   mon_change   : change strobe towards the device counter (registered)
//   mon_on_off   : direction for mon_change
//   shadow_count : mirror of the device counter after all issued strobes
//
// Optional feature: define IOT_SATURATE_GUARD_EN to reject up-events at
// MAX_COUNT and down-events at zero instead of letting the count wrap.

module iot_event_arbiter #(
    parameter logic [7:0] MAX_COUNT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] req_on,
    output logic [3:0] gnt,
    output logic [3:0] rej,
    output logic       mon_change,
    output logic       mon_on_off,
    output logic [7:0] shadow_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] rej_q, rej_d;
    logic       chg_q, chg_d;
    logic       onoff_q, onoff_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] elig;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       win_on;
    logic       reject;

`ifndef IOT_SATURATE_GUARD_EN
    logic unused_max_count;
    assign unused_max_count = ^MAX_COUNT;
`endif

    // A requester being answered this cycle sits out one arbitration so the
    // same held request cannot be counted twice.
    always_comb begin
        elig  = req & ~((state_q == ISSUE) ? (gnt_q | rej_q) : 4'b0000);
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        ptr_d   = ptr_q;
        gnt_d   = 4'b0000;
        rej_d   = 4'b0000;
        chg_d   = 1'b0;
        onoff_d = 1'b0;
        cnt_d   = cnt_q;
        win_on  = req_on[win];
        reject  = 1'b0;
`ifdef IOT_SATURATE_GUARD_EN
        reject  = win_on ? (cnt_q == MAX_COUNT) : (cnt_q == 8'd0);
`endif
        if (found) begin
            state_d = ISSUE;
            ptr_d   = win;
            if (reject) begin
                rej_d[win] = 1'b1;
            end else begin
                gnt_d[win] = 1'b1;
                chg_d      = 1'b1;
                onoff_d    = win_on;
                cnt_d      = win_on ? cnt_q + 8'd1 : cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            gnt_q   <= 4'b0000;
            rej_q   <= 4'b0000;
            chg_q   <= 1'b0;
            onoff_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rej_q   <= rej_d;
            chg_q   <= chg_d;
            onoff_q <= onoff_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign rej          = rej_q;
    assign mon_change   = chg_q;
    assign mon_on_off   = onoff_q;
    assign shadow_count = cnt_q;

endmodule
